// File: rtl/fifo_read_ctrl_if.sv
// Read-side bundle of an async FIFO: synchronized write pointer, memory read port and output stream.
// master = read controller, slave = surrounding logic (memory, consumer, write-pointer sync).
interface fifo_read_ctrl_if #(
   parameter int unsigned data_Size    = 8,
   parameter int unsigned address_Size = 3
);
   logic [address_Size:0]   rq2_wPtr;
   logic [data_Size-1:0]    mem_Data;
   logic                    out_Ready;
   logic [address_Size-1:0] r_Addr;
   logic [address_Size:0]   r_Ptr;
   logic                    fifo_Empty;
   logic                    out_Valid;
   logic [data_Size-1:0]    out_Data;
   logic [address_Size:0]   r_Count;

   modport master (
      input  rq2_wPtr, mem_Data, out_Ready,
      output r_Addr, r_Ptr, fifo_Empty, out_Valid, out_Data, r_Count
   );

   modport slave (
      output rq2_wPtr, mem_Data, out_Ready,
      input  r_Addr, r_Ptr, fifo_Empty, out_Valid, out_Data, r_Count
   );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Async-FIFO read controller: binary/Gray read pointer, registered empty flag and a one-word
// registered output stage that pops whenever it is empty or being drained.
module fifo_read_ctrl #(
   parameter int unsigned data_Size    = 8,
   parameter int unsigned address_Size = 3
) (
   input logic             r_Clk,
   input logic             r_Rst,
   fifo_read_ctrl_if.master bus
);

   logic [address_Size:0]  rbin_q, rbin_d;
   logic [address_Size:0]  rptr_q, rptr_d;
   logic [address_Size:0]  wbin;
   logic [data_Size-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   empty_q, empty_d;
   logic                   pop;

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      wbin = '0;
      for (int i = 0; i <= int'(address_Size); i++) begin
         wbin[i] = ^(bus.rq2_wPtr >> i);
      end
   end

   always_comb begin
      pop     = !empty_q && (!valid_q || bus.out_Ready);
      rbin_d  = rbin_q;
      data_d  = data_q;
      valid_d = valid_q;
      if (pop) begin
         rbin_d  = rbin_q + (address_Size + 1)'(1);
         data_d  = bus.mem_Data;
         valid_d = 1'b1;
      end else if (valid_q && bus.out_Ready) begin
         valid_d = 1'b0;
      end
      rptr_d  = rbin_d ^ (rbin_d >> 1);
      // Compare against the pointer value after this edge's pop so empty never lags a cycle.
      empty_d = (rptr_d == bus.rq2_wPtr);
   end

   always_ff @(posedge r_Clk or posedge r_Rst) begin
      if (r_Rst) begin
         rbin_q  <= '0;
         rptr_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         rbin_q  <= rbin_d;
         rptr_q  <= rptr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         empty_q <= empty_d;
      end
   end

   assign bus.r_Addr     = rbin_q[address_Size-1:0];
   assign bus.r_Ptr      = rptr_q;
   assign bus.fifo_Empty = empty_q;
   assign bus.out_Valid  = valid_q;
   assign bus.out_Data   = data_q;
   // Forced to zero during reset so the occupancy reads cleanly whatever the write side shows.
   assign bus.r_Count    = r_Rst ? '0 : (wbin - rbin_q);

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: directed vector table, hand sequences for full and
// asynchronous mid-stream reset, then a randomized stream against a count-based reference model.
module tb_fifo_read_ctrl;
   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 3;
   localparam int          DEPTH = 8;

   typedef struct {
      logic       rst;
      logic [3:0] wptr;
      logic       ready;
      logic       e_empty;
      logic       e_valid;
      logic [7:0] e_data;
      logic [3:0] e_ptr;
      logic [2:0] e_addr;
      logic [3:0] e_count;
   } vec_t;

   logic r_Clk = 1'b0;
   logic r_Rst;
   logic [DW-1:0] mem_arr [DEPTH];
   int checks = 0;
   int errors = 0;

   fifo_read_ctrl_if #(.data_Size(DW), .address_Size(AW)) bus ();

   assign bus.mem_Data = mem_arr[bus.r_Addr];

   fifo_read_ctrl #(.data_Size(DW), .address_Size(AW)) dut (
      .r_Clk (r_Clk),
      .r_Rst (r_Rst),
      .bus   (bus)
   );

   always #5 r_Clk = ~r_Clk;

   function automatic logic [3:0] gray(input int v);
      logic [3:0] b;
      b = v[3:0];
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic e_empty, input logic e_valid,
                            input logic [7:0] e_data, input logic [3:0] e_ptr,
                            input logic [2:0] e_addr, input logic [3:0] e_count);
      check({tag, ".empty"}, 32'(bus.fifo_Empty), 32'(e_empty));
      check({tag, ".valid"}, 32'(bus.out_Valid), 32'(e_valid));
      check({tag, ".data"},  32'(bus.out_Data), 32'(e_data));
      check({tag, ".ptr"},   32'(bus.r_Ptr), 32'(e_ptr));
      check({tag, ".addr"},  32'(bus.r_Addr), 32'(e_addr));
      check({tag, ".count"}, 32'(bus.r_Count), 32'(e_count));
   endtask

   task automatic do_reset();
      r_Rst = 1'b1;
      bus.rq2_wPtr = '0;
      @(posedge r_Clk);
      #1;
      r_Rst = 1'b0;
   endtask

   vec_t tbl [10];
   int   rd, wr, rd_n;
   logic m_empty, m_valid, n_empty, n_valid, m_pop;
   logic [7:0] m_data, n_data;
   bit   found, saw8;

   initial begin
      r_Rst = 1'b1;
      bus.rq2_wPtr  = '0;
      bus.out_Ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_arr[i] = 8'($urandom);

      // Reset with random inputs, including across clock edges.
      for (int i = 0; i < 4; i++) begin
         bus.rq2_wPtr  = 4'($urandom);
         bus.out_Ready = 1'($urandom);
         for (int k = 0; k < DEPTH; k++) mem_arr[k] = 8'($urandom);
         #2;
         check_all($sformatf("reset%0d", i), 1'b1, 1'b0, 8'h00, 4'h0, 3'd0, 4'd0);
         @(posedge r_Clk);
         #1;
      end

      // Single word, reset, then backpressure followed by two back-to-back pops.
      mem_arr[0] = 8'hA5;
      mem_arr[1] = 8'h3C;
      mem_arr[2] = 8'h7E;
      tbl[0] = '{1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 3'd0, 4'd1};
      tbl[1] = '{1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 8'hA5, 4'b0001, 3'd1, 4'd0};
      tbl[2] = '{1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 8'hA5, 4'b0001, 3'd1, 4'd0};
      tbl[3] = '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 8'h00, 4'b0000, 3'd0, 4'd0};
      tbl[4] = '{1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 3'd0, 4'd3};
      tbl[5] = '{1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 8'hA5, 4'b0001, 3'd1, 4'd2};
      tbl[6] = '{1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 8'hA5, 4'b0001, 3'd1, 4'd2};
      tbl[7] = '{1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 8'h3C, 4'b0011, 3'd2, 4'd1};
      tbl[8] = '{1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 8'h7E, 4'b0010, 3'd3, 4'd0};
      tbl[9] = '{1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 8'h7E, 4'b0010, 3'd3, 4'd0};
      for (int i = 0; i < 10; i++) begin
         r_Rst         = tbl[i].rst;
         bus.rq2_wPtr  = tbl[i].wptr;
         bus.out_Ready = tbl[i].ready;
         @(posedge r_Clk);
         #1;
         check_all($sformatf("vec%0d", i), tbl[i].e_empty, tbl[i].e_valid, tbl[i].e_data,
                   tbl[i].e_ptr, tbl[i].e_addr, tbl[i].e_count);
      end

      // Full FIFO: occupancy 8 before the first pop, 7 after it.
      do_reset();
      bus.rq2_wPtr  = 4'b1100;
      bus.out_Ready = 1'b0;
      #1;
      check("full.count_pre", 32'(bus.r_Count), 32'd8);
      @(posedge r_Clk);
      #1;
      check("full.empty1", 32'(bus.fifo_Empty), 32'd0);
      check("full.count1", 32'(bus.r_Count), 32'd8);
      @(posedge r_Clk);
      #1;
      check("full.valid2", 32'(bus.out_Valid), 32'd1);
      check("full.count2", 32'(bus.r_Count), 32'd7);
      check("full.empty2", 32'(bus.fifo_Empty), 32'd0);

      // Mid-stream asynchronous reset with rBin=5 and a word held.
      do_reset();
      bus.rq2_wPtr  = gray(7);
      bus.out_Ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(posedge r_Clk);
         #1;
         if (bus.r_Addr == 3'd5 && bus.out_Valid) found = 1'b1;
      end
      check("midrst.reach_rbin5", 32'(found), 32'd1);
      r_Rst = 1'b1;
      #2;
      check_all("midrst", 1'b1, 1'b0, 8'h00, 4'h0, 3'd0, 4'd0);
      @(posedge r_Clk);
      #1;
      r_Rst = 1'b0;

      // Randomized stream against a count-based model; first 40 cycles stream flat out.
      bus.rq2_wPtr  = '0;
      bus.out_Ready = 1'b1;
      rd = 0; wr = 0;
      m_empty = 1'b1; m_valid = 1'b0; m_data = 8'h00;
      saw8 = 1'b0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         m_pop   = !m_empty && (!m_valid || bus.out_Ready);
         n_data  = m_data;
         n_valid = m_valid;
         rd_n    = rd;
         if (m_pop) begin
            n_data  = mem_arr[rd % DEPTH];
            n_valid = 1'b1;
            rd_n    = rd + 1;
         end else if (m_valid && bus.out_Ready) begin
            n_valid = 1'b0;
         end
         n_empty = ((rd_n % 16) == (wr % 16));
         @(posedge r_Clk);
         #1;
         rd = rd_n; m_data = n_data; m_valid = n_valid; m_empty = n_empty;
         check_all($sformatf("rand%0d", cyc), m_empty, m_valid, m_data, gray(rd % 16),
                   3'(rd % DEPTH), 4'(wr - rd));
         if (bus.r_Ptr == 4'b1000) saw8 = 1'b1;
         if (cyc < 40) begin
            bus.out_Ready = 1'b1;
            if (wr - rd < DEPTH) begin
               mem_arr[wr % DEPTH] = 8'($urandom);
               wr++;
            end
         end else begin
            bus.out_Ready = ($urandom_range(0, 3) != 0);
            if (wr - rd < DEPTH && $urandom_range(0, 2) != 0) begin
               mem_arr[wr % DEPTH] = 8'($urandom);
               wr++;
            end
         end
         bus.rq2_wPtr = gray(wr % 16);
      end
      check("rand.ptr_passed_1000", 32'(saw8), 32'd1);
      check("rand.made_progress", 32'(rd > 100), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
